// File: rtl/arb_mux_pkg.sv
// Shared constants and state encoding for the arb_mux output arbiter.
package arb_mux_pkg;

   localparam int ARB_N_DEF   = 32;
   localparam int ARB_NCH_DEF = 3;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Rotating-priority picker: first valid channel at or above ptr, wrapping to 0.
module rr_pick #(
   parameter int NCH = 3,
   parameter int SW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] valid,
   input  logic [SW-1:0]  ptr,
   output logic [NCH-1:0] grant,
   output logic [SW-1:0]  idx,
   output logic           any
);

   int   c;
   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int k = 0; k < NCH; k++) begin
         c = int'(ptr) + k;
         if (c >= NCH) c = c - NCH;
         if (!found && valid[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = SW'(c);
         end
      end
   end

   assign any = |valid;

endmodule

// File: rtl/arb_mux.sv
// N-channel arbiter feeding a one-entry registered output stage.
// Define ARB_MUX_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module arb_mux
   import arb_mux_pkg::*;
#(
   parameter int N   = ARB_N_DEF,
   parameter int NCH = ARB_NCH_DEF,
   parameter int SW  = $clog2(NCH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH*N-1:0] in_data,
   input  logic [NCH-1:0] in_valid,
   output logic [NCH-1:0] in_ready,
   output logic [N-1:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [SW-1:0]  out_sel
);

   arb_state_e     state_q, state_d;
   logic [N-1:0]   data_q, data_d;
   logic [SW-1:0]  sel_q, sel_d;
   logic [NCH-1:0] grant;
   logic [SW-1:0]  g_idx;
   logic [SW-1:0]  pick_ptr;
   logic           any_req;
   logic           load;

`ifdef ARB_MUX_FIXED_PRIO_EN
   // Searching from channel 0 every cycle gives strict lowest-index priority.
   assign pick_ptr = '0;
`else
   logic [SW-1:0] ptr_q, ptr_d;

   assign pick_ptr = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (load) ptr_d = (g_idx == SW'(NCH - 1)) ? '0 : g_idx + SW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`endif

   rr_pick #(.NCH(NCH), .SW(SW)) u_pick (
      .valid (in_valid),
      .ptr   (pick_ptr),
      .grant (grant),
      .idx   (g_idx),
      .any   (any_req)
   );

   assign out_valid = (state_q == ST_FULL);
   assign load      = any_req && (!out_valid || out_ready);
   // Reset gating keeps in_ready low even though the emptied stage would accept.
   assign in_ready  = (load && !rst) ? grant : '0;
   assign out_data  = data_q;
   assign out_sel   = sel_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      if (load) begin
         state_d = ST_FULL;
         data_d  = in_data[int'(g_idx)*N +: N];
         sel_d   = g_idx;
      end else if (out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux (NCH=3, N=32); expected beats queued by stimulus, popped on handshake.
module tb_arb_mux;

   localparam int N   = 32;
   localparam int NCH = 3;
   localparam int SW  = 2;

   logic             clk;
   logic             rst;
   logic [NCH*N-1:0] in_data;
   logic [NCH-1:0]   in_valid;
   logic [NCH-1:0]   in_ready;
   logic [N-1:0]     out_data;
   logic             out_valid;
   logic             out_ready;
   logic [SW-1:0]    out_sel;

   typedef struct {
      logic [SW-1:0] sel;
      logic [N-1:0]  data;
   } beat_t;

   beat_t exp_q[$];
   int    total = 0;
   int    bad   = 0;

   arb_mux #(.N(N), .NCH(NCH), .SW(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int sel, input logic [N-1:0] data);
      beat_t b;
      b.sel  = SW'(sel);
      b.data = data;
      exp_q.push_back(b);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted output beat must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got sel=%0d data=0x%0h want no beat at %0t", out_sel, out_data, $time);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            if (out_sel !== e.sel || out_data !== e.data) begin
               bad++;
               $display("FAIL sb_beat: got sel=%0d data=0x%0h want sel=%0d data=0x%0h at %0t",
                        out_sel, out_data, e.sel, e.data, $time);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rr_sel[4];
      logic [N-1:0] chd[3];

`ifdef ARB_MUX_FIXED_PRIO_EN
      rr_sel = '{0, 0, 0, 0};
`else
      rr_sel = '{0, 1, 2, 0};
`endif
      chd = '{32'hA0, 32'hB1, 32'hC2};

      rst       = 1'b1;
      in_valid  = '0;
      out_ready = 1'b0;
      in_data   = '0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  out_data,       32'd0);
      chk("rst_out_sel",   32'(out_sel),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk);
      cyc();
      rst = 1'b0;
      in_data[0*N +: N] = chd[0];
      in_data[1*N +: N] = chd[1];
      in_data[2*N +: N] = chd[2];

      // All three requesting, sink always ready
      in_valid  = 3'b111;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_exp(rr_sel[i], chd[rr_sel[i]]);
         @(negedge clk);
         chk("rr_in_ready", 32'(in_ready), 32'(1) << rr_sel[i]);
         if (i > 0) chk("rr_out_valid", 32'(out_valid), 32'd1);
         cyc();
      end
      in_valid = '0;
      @(negedge clk);
      chk("drop_in_ready", 32'(in_ready), 32'd0);
      cyc();
      @(negedge clk);
      chk("drop_out_valid", 32'(out_valid), 32'd0);
      chk("drop_out_data",  out_data,       32'hA0);
      cyc();

      // Single requester on ch2
      in_data[2*N +: N] = 32'h1234;
      in_valid = 3'b100;
      for (int i = 0; i < 3; i++) begin
         push_exp(2, 32'h1234);
         @(negedge clk);
         chk("single_in_ready", 32'(in_ready), 32'b100);
         cyc();
      end
      in_valid = '0;
      cyc();
      cyc();

      // Backpressure with ch1 beat held
      in_valid  = 3'b010;
      out_ready = 1'b0;
      push_exp(1, 32'hB1);
      @(negedge clk);
      chk("bp_load_in_ready", 32'(in_ready), 32'b010);
      cyc();
      in_valid = 3'b001;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_out_data",  out_data,       32'hB1);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         cyc();
      end
      out_ready = 1'b1;
      push_exp(0, 32'hA0);
      @(negedge clk);
      chk("bp_release_in_ready", 32'(in_ready), 32'b001);
      cyc();
      in_valid = '0;
      @(negedge clk);
      chk("bp_next_data", out_data, 32'hA0);
      cyc();
      cyc();

      // Reset while holding an undelivered beat
      in_valid  = 3'b010;
      out_ready = 1'b0;
      cyc();
      @(negedge clk);
      chk("prerst_out_valid", 32'(out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data",  out_data,       32'd0);
      chk("midrst_out_sel",   32'(out_sel),   32'd0);
      chk("midrst_in_ready",  32'(in_ready),  32'd0);
      cyc();
      rst       = 1'b0;
      in_valid  = 3'b111;
      out_ready = 1'b1;
      push_exp(0, 32'hA0);
      @(negedge clk);
      chk("postrst_in_ready", 32'(in_ready), 32'b001);
      cyc();
      push_exp(rr_sel[1], chd[rr_sel[1]]);
      @(negedge clk);
      cyc();
      in_valid = '0;
      cyc();
      cyc();

`ifdef ARB_MUX_FIXED_PRIO_EN
      // ch1 and ch2 requesting: ch1 always wins, ch2 starves
      in_valid = 3'b110;
      for (int i = 0; i < 4; i++) begin
         push_exp(1, 32'hB1);
         @(negedge clk);
         chk("fixed_in_ready", 32'(in_ready), 32'b010);
         cyc();
      end
      in_valid = '0;
      cyc();
      cyc();
`endif

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
